io_pad_bank: RTL and testbench

//  Parametrised bank of NUM_CH bidirectional pad channels between SoC cores (GPIO, I2C, USB) and the top-level IOBUFs.
//  Per channel: registered push-pull/open-drain output control, N-stage input synchroniser,

---
 rtl/io_pad_bank_pkg.sv | 25 ++
 rtl/io_pad_filter.sv | 59 +++++
 rtl/io_pad_bank.sv | 79 +++++++
 tb/tb_io_pad_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/io_pad_bank_pkg.sv
// Shared types, limits and helpers for io_pad_bank and its per-channel filter.
package io_pad_bank_pkg;

  localparam int MAX_CH          = 64;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  typedef enum logic {
    PAD_PUSH_PULL  = 1'b0,
    PAD_OPEN_DRAIN = 1'b1
  } pad_mode_t;

  function automatic bit params_ok(input int num_ch, input int sync_stages, input int filt_w);
    return (num_ch >= 1) && (num_ch <= MAX_CH) &&
           (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES) &&
           (filt_w >= 1);
  endfunction

  // Returns {pad_o, pad_t}; open-drain only ever pulls low, releasing to Hi-Z for a 1.
  function automatic logic [1:0] pad_drive(input pad_mode_t mode, input logic o, input logic oe);
    if (mode == PAD_OPEN_DRAIN) return {1'b0, ~(oe & ~o)};
    else                        return {o, ~oe};
  endfunction

endpackage

// File: rtl/io_pad_filter.sv
// One pad channel input path: synchroniser chain, glitch-filter counter and
// registered rise/fall pulses trailing the filtered value by one cycle.
module io_pad_filter
  import io_pad_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pad,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_sync,
  output logic              o_core_i,
  output logic              o_rise,
  output logic              o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_W-1:0]      r_cnt;
  logic                   r_core_i;
  logic                   r_core_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync_i;

  assign w_sync_i = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_core_i <= 1'b0;
      r_core_d <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      // cnt never exceeds filt_len, and a lowered filt_len commits via >=, so no wrap.
      if (w_sync_i == r_core_i) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_filt_len) begin
        r_core_i <= w_sync_i;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_core_d <= r_core_i;
      r_rise   <= r_core_i & ~r_core_d;
      r_fall   <= ~r_core_i & r_core_d;
    end
  end

  assign o_sync   = w_sync_i;
  assign o_core_i = r_core_i;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/io_pad_bank.sv
// Bank of bidirectional pad channels: registered pad drive plus filtered inputs.
// Define IO_PAD_BANK_SNOOP_EN to build the registered snoop view of each line.
module io_pad_bank
  import io_pad_bank_pkg::*;
#(
  parameter int NUM_CH      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] core_o,
  input  logic [NUM_CH-1:0] core_oe,
  input  logic [NUM_CH-1:0] core_od,
  input  logic [FILT_W-1:0] filt_len,
  output logic [NUM_CH-1:0] core_i,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  input  logic [NUM_CH-1:0] pad_i,
  output logic [NUM_CH-1:0] pad_o,
  output logic [NUM_CH-1:0] pad_t,
  output logic [NUM_CH-1:0] snoop
);

  if (!params_ok(NUM_CH, SYNC_STAGES, FILT_W)) begin : g_bad_params
    $error("io_pad_bank: NUM_CH/SYNC_STAGES/FILT_W out of range");
  end

  logic [NUM_CH-1:0] r_pad_o;
  logic [NUM_CH-1:0] r_pad_t;
  logic [NUM_CH-1:0] w_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pad_o <= '0;
      r_pad_t <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        {r_pad_o[i], r_pad_t[i]} <= pad_drive(pad_mode_t'(core_od[i]), core_o[i], core_oe[i]);
      end
    end
  end

  assign pad_o = r_pad_o;
  assign pad_t = r_pad_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    io_pad_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_filt (
      .clk        (clk),
      .rst        (rst),
      .i_pad      (pad_i[g]),
      .i_filt_len (filt_len),
      .o_sync     (w_sync[g]),
      .o_core_i   (core_i[g]),
      .o_rise     (rise[g]),
      .o_fall     (fall[g])
    );
  end

`ifdef IO_PAD_BANK_SNOOP_EN
  logic [NUM_CH-1:0] r_snoop;

  // Driven value while driving, otherwise what the synchroniser sees.
  always_ff @(posedge clk) begin
    if (rst) r_snoop <= '0;
    else     r_snoop <= (~r_pad_t & r_pad_o) | (r_pad_t & w_sync);
  end

  assign snoop = r_snoop;
`else
  logic w_unused_sync;
  assign w_unused_sync = ^w_sync;
  assign snoop         = '0;
`endif

endmodule

// File: tb/tb_io_pad_bank.sv
// Directed bench for io_pad_bank: output-path vector table plus hand-timed filter sequences.
module tb_io_pad_bank;

  localparam int NCH = 24;
  localparam int FW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] core_o, core_oe, core_od, pad_i;
  logic [FW-1:0]  filt_len;
  logic [NCH-1:0] core_i, rise, fall, pad_o, pad_t, snoop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_pad_bank #(.NUM_CH(NCH), .SYNC_STAGES(2), .FILT_W(FW)) dut (
    .clk(clk), .rst(rst), .core_o(core_o), .core_oe(core_oe), .core_od(core_od),
    .filt_len(filt_len), .core_i(core_i), .rise(rise), .fall(fall),
    .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t), .snoop(snoop)
  );

  typedef struct {
    logic [NCH-1:0] o, oe, od, exp_o, exp_t;
  } ovec_t;

  ovec_t vt[7];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [NCH-1:0] snoop_all_hi;
  logic [NCH-1:0] snoop_ch0_hi;

  initial begin
`ifdef IO_PAD_BANK_SNOOP_EN
    snoop_all_hi = '1;
    snoop_ch0_hi = 24'h000001;
`else
    snoop_all_hi = '0;
    snoop_ch0_hi = '0;
`endif

    vt[0] = '{o:24'hA5A5A5, oe:24'hFFFFFF, od:24'h000000, exp_o:24'hA5A5A5, exp_t:24'h000000};
    vt[1] = '{o:24'hFFFFFF, oe:24'h0F0F0F, od:24'h000000, exp_o:24'hFFFFFF, exp_t:24'hF0F0F0};
    vt[2] = '{o:24'h00FF00, oe:24'hFFFFFF, od:24'hFFFFFF, exp_o:24'h000000, exp_t:24'h00FF00};
    vt[3] = '{o:24'hFFFFFF, oe:24'hFFFFFF, od:24'h00000F, exp_o:24'hFFFFF0, exp_t:24'h00000F};
    vt[4] = '{o:24'h000001, oe:24'h000001, od:24'h000000, exp_o:24'h000001, exp_t:24'hFFFFFE};
    vt[5] = '{o:24'h000001, oe:24'h000000, od:24'h000000, exp_o:24'h000001, exp_t:24'hFFFFFF};
    vt[6] = '{o:24'h000000, oe:24'h000020, od:24'h000020, exp_o:24'h000000, exp_t:24'hFFFFDF};

    // Reset with random inputs
    rst = 1'b1;
    core_o = NCH'($urandom); core_oe = NCH'($urandom); core_od = NCH'($urandom);
    pad_i = NCH'($urandom); filt_len = FW'($urandom);
    step(3);
    chk("rst_pad_t", pad_t, 24'hFFFFFF);
    chk("rst_pad_o", pad_o, 0);
    chk("rst_core_i", core_i, 0);
    chk("rst_rise_fall", {rise, fall}, 0);
    chk("rst_snoop", snoop, 0);
    rst = 1'b0; pad_i = '0; core_o = '0; core_oe = '0; core_od = '0; filt_len = 0;
    step(1);
    chk("rel_rise_fall", {rise, fall}, 0);
    chk("rel_core_i", core_i, 0);

    // Output path table
    for (int v = 0; v < 7; v++) begin
      core_o = vt[v].o; core_oe = vt[v].oe; core_od = vt[v].od;
      step(1);
      chk($sformatf("vec%0d_pad_o", v), pad_o, vt[v].exp_o);
      chk($sformatf("vec%0d_pad_t", v), pad_t, vt[v].exp_t);
    end

    // ch0 push-pull drive and snoop one cycle behind
    core_o = 24'h000001; core_oe = 24'h000001; core_od = '0;
    step(1);
    chk("pp_ch0_pad", {pad_o[0], pad_t[0]}, 2'b10);
    step(1);
    chk("pp_ch0_snoop", snoop, snoop_ch0_hi);
    core_oe = '0;
    step(1);
    chk("pp_ch0_release", pad_t[0], 1'b1);

    // ch5 open-drain released, external pull-up then low; filt_len=3
    filt_len = 3; core_od = 24'h000020; core_oe = 24'h000020; core_o = 24'h000020;
    pad_i = 24'h000020;
    step(1);
    chk("od_ch5_released", {pad_o[5], pad_t[5]}, 2'b01);
    step(10);
    chk("od_ch5_high", core_i[5], 1'b1);
    pad_i = '0;
    step(5);
    chk("od_ch5_pre", core_i[5], 1'b1);
    step(1);
    chk("od_ch5_low", core_i[5], 1'b0);
    core_od = '0; core_oe = '0; core_o = '0;
    step(5);

    // 3-cycle glitch on ch1 rejected
    pad_i = 24'h000002;
    step(3);
    pad_i = '0;
    for (int k = 4; k <= 12; k++) begin
      step(1);
      chk($sformatf("glitch_k%0d", k), {core_i[1], rise[1]}, 2'b00);
    end

    // 4-cycle pulse on ch1 passes
    pad_i = 24'h000002;
    step(4);
    pad_i = '0;
    step(1);
    chk("pulse_k5_core", core_i[1], 1'b0);
    step(1);
    chk("pulse_k6_core", core_i, 24'h000002);
    chk("pulse_k6_rise", rise, 0);
    step(1);
    chk("pulse_k7_rise", rise, 24'h000002);
    step(1);
    chk("pulse_k8_rise", {rise, fall}, 0);
    step(2);
    chk("pulse_k10_core", core_i[1], 1'b0);
    chk("pulse_k10_fall", fall, 0);
    step(1);
    chk("pulse_k11_fall", {rise, fall}, {24'h0, 24'h000002});
    step(1);
    chk("pulse_k12_fall", fall, 0);

    // filt_len=0: 3-cycle latency on ch2
    filt_len = 0; pad_i = 24'h000004;
    step(2);
    chk("fl0_k2", core_i[2], 1'b0);
    step(1);
    chk("fl0_k3", core_i[2], 1'b1);
    pad_i = '0;
    step(6);

    // filt_len 15 -> 2 while cnt=8 on ch3
    filt_len = 15; pad_i = 24'h000008;
    step(10);
    chk("fl_drop_pre", core_i[3], 1'b0);
    filt_len = 2;
    step(1);
    chk("fl_drop_commit", core_i[3], 1'b1);
    pad_i = '0;
    step(8);

    // All channels rise, reset mid-count, then restart from zero
    filt_len = 5; core_oe = '0; pad_i = '1;
    step(4);
    rst = 1'b1;
    step(1);
    chk("midrst_core_i", core_i, 0);
    chk("midrst_pulses", {rise, fall}, 0);
    rst = 1'b0;
    step(3);
    chk("all_snoop_k3", snoop, snoop_all_hi);
    step(4);
    chk("all_k7_core", core_i, 0);
    chk("all_k7_pulses", {rise, fall}, 0);
    step(1);
    chk("all_k8_core", core_i, 24'hFFFFFF);
    step(1);
    chk("all_k9_rise", rise, 24'hFFFFFF);
    step(1);
    chk("all_k10_rise", rise, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
